aes_round_ctrl: RTL

Iterative AES-128 encryption controller. It sequences the combinational round datapath (`aes_subbytes` → `aes_shiftrows` → `aes_mixcolumns` → `aes_addroundkey`) over ten rounds, one round per clock. It expands the round keys on the fly, one key per round. The block sits between a valid/ready block source and a valid/ready ciphertext sink, and is the first clocked block in the AES encryption path.

---
 rtl/aes_round_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryption controller.
// Accepts a plaintext/key pair on a valid/ready input and runs ten rounds at
// one round per clock, expanding each round key on the fly. The ciphertext is
// then held on a valid/ready output until the sink takes it.
// Optional build macro: AES_ROUND_DBG_EN adds dbg_round/dbg_state ports that
// expose the round counter and the state register.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef AES_ROUND_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [127:0] dbg_state
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  // Forward S-box, entry 0 in the top byte; row n holds inputs n0..nf.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte b lives at bit offset (255-b)*8, which is just ~b followed by 3 zeros.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Byte k of the block is row k%4, column k/4; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      o[103-32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_word({rk[23:0], rk[31:24]}) ^ {rc, 24'h0};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  fsm_e         fsm_q;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   round_q;
  logic [127:0] out_data_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [127:0] sb_sr;

  // One full round: next round key, then SB->SR->(MC)->ARK on the state.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    rk_d    = key_expand(rk_q, rcon(round_q));
    sb_sr   = shift_rows(sub_bytes(state_q));
    state_d = ((round_q == LAST_ROUND) ? sb_sr : mix_columns(sb_sr)) ^ rk_d;
  end

  // Control FSM with registered handshake outputs; reset discards any block in flight.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      round_q     <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= in_data ^ in_key;
            rk_q       <= in_key;
            round_q    <= 4'd1;
            in_ready_q <= 1'b0;
            fsm_q      <= RUN;
          end
        end
        RUN: begin
          state_q <= state_d;
          rk_q    <= rk_d;
          if (round_q == LAST_ROUND) begin
            out_data_q  <= state_d;
            out_valid_q <= 1'b1;
            round_q     <= 4'd0;
            fsm_q       <= DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here: the next accept comes from IDLE.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fsm_q       <= IDLE;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef AES_ROUND_DBG_EN
  assign dbg_round = round_q;
  assign dbg_state = state_q;
`endif

endmodule
